// File: rtl/clk_mon.sv
// Slow-clock monitor: edge detection, half-period measurement, and a lock/loss tracker.
// Latency: rise/fall/half_period/locked/lost are registered 3 cycles after clock_in is first sampled at a new level.
// Backpressure: none; this block only observes clock_in and always accepts it.
module clk_mon #(
  parameter int clock_rate = 10,  // expected full period in clock cycles; must be even and >= 4
  parameter int tolerance  = 1,   // allowed |half-period - clock_rate/2| in cycles
  parameter int lock_count = 4,   // consecutive in-tolerance half-periods needed to lock; >= 1
  localparam int half    = clock_rate / 2,
  localparam int timeout = 4 * half,
  localparam int W       = $clog2(timeout + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clock_in,
  output logic         rise,
  output logic         fall,
  output logic [W-1:0] half_period,
  output logic         locked,
  output logic         lost
);

  localparam int MCW = (lock_count > 1) ? $clog2(lock_count) : 1;

  localparam logic [W:0]   HALF_V = (W+1)'(half);
  localparam logic [W:0]   TOL_V  = (W+1)'(tolerance);
  localparam logic [W-1:0] TMO_V  = W'(timeout);
  localparam logic [W-1:0] TMO_M1 = W'(timeout - 1);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  logic           s0_q, s1_q, s2_q;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   half_period_q;
  logic           rise_q, fall_q;
  logic           locked_q, lost_q;
  logic [MCW-1:0] mc_q, mc_d;
  state_t         state_q, state_d;

  logic           edge_det;
  logic           timeout_hit;
  logic           in_tol;
  logic [W:0]     interval;
  logic [W:0]     dev;

  // s1 is the synchronised level, s2 its previous value; any difference is an edge.
  assign edge_det    = s1_q ^ s2_q;
  assign timeout_hit = !edge_det && (cnt_q == TMO_M1);

  // Interval is taken one bit wider than cnt so a saturated count cannot wrap to a small value.
  assign interval = {1'b0, cnt_q} + (W+1)'(1);
  assign dev      = (interval >= HALF_V) ? (interval - HALF_V) : (HALF_V - interval);
  assign in_tol   = (dev <= TOL_V);

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s0_q <= clock_in;
      s1_q <= s0_q;
      s2_q <= s1_q;
    end
  end

  // Interval counter: restart on an edge, otherwise count up and stick at timeout.
  always_comb begin
    cnt_d = cnt_q;
    if (edge_det) begin
      cnt_d = '0;
    end else if (cnt_q != TMO_V) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Lock tracker next state; an edge always wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    if (edge_det) begin
      case (state_q)
        ACQUIRE, LOST: begin
          // First interval after acquisition or loss has an arbitrary start, so it is not judged.
          state_d = TRACK;
          mc_d    = '0;
        end
        TRACK: begin
          if (in_tol) begin
            if ((int'(mc_q) + 1) == lock_count) begin
              state_d = LOCKED;
              mc_d    = '0;
            end else begin
              mc_d = mc_q + MCW'(1);
            end
          end else begin
            mc_d = '0;
          end
        end
        LOCKED: begin
          if (!in_tol) begin
            state_d = TRACK;
            mc_d    = '0;
          end
        end
        default: begin
          state_d = ACQUIRE;
          mc_d    = '0;
        end
      endcase
    end else if (timeout_hit) begin
      state_d = LOST;
      mc_d    = '0;
    end
  end

  // Registered state, counters and outputs, all updated together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ACQUIRE;
      mc_q          <= '0;
      cnt_q         <= '0;
      half_period_q <= '0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      locked_q      <= 1'b0;
      lost_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_q     <= mc_d;
      cnt_q    <= cnt_d;
      rise_q   <= edge_det && s1_q;
      fall_q   <= edge_det && !s1_q;
      locked_q <= (state_d == LOCKED);
      lost_q   <= (state_d == LOST);
      if (edge_det) begin
        half_period_q <= interval[W-1:0];
      end
    end
  end

  assign rise        = rise_q;
  assign fall        = fall_q;
  assign half_period = half_period_q;
  assign locked      = locked_q;
  assign lost        = lost_q;

endmodule
